// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control and output bundle for the multi-channel clock divider
interface clk_div_multi_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 27,
  parameter int SEL_W = (CH > 1) ? $clog2(CH) : 1
);
  logic [CH-1:0]    en;
  logic             sync;
  logic             cfg_we;
  logic [SEL_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;
  modport master(output en, sync, cfg_we, cfg_ch, cfg_div, input clk_out, tick);
  modport slave(input en, sync, cfg_we, cfg_ch, cfg_div, output clk_out, tick);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: CH independent programmable dividers producing 50% clk_out and tick strobes
module clk_div_multi #(
  parameter int          CH          = 4,
  parameter int          CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = 32'd1 << 26,
  parameter int          SEL_W       = (CH > 1) ? $clog2(CH) : 1
) (
  input logic clk,
  input logic rst,
  clk_div_multi_if.slave bus
);
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_div, r_cnt;
    logic             r_clk, r_tick;
    logic             w_wr, w_restart, w_term;
    assign w_wr      = bus.cfg_we && bus.cfg_ch == SEL_W'(g);
    assign w_restart = bus.sync || w_wr;
    assign w_term    = r_cnt == r_div - CNT_W'(1);
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_div  <= CNT_W'(DEFAULT_DIV);
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        if (w_wr) r_div <= bus.cfg_div;
        if (w_restart || r_div == '0) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else if (!bus.en[g]) begin
          r_tick <= 1'b0;
        end else if (w_term) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_tick <= 1'b0;
        end
      end
    assign bus.clk_out[g] = r_clk;
    assign bus.tick[g]    = r_tick;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed checks of two divider builds against a cycle-count model
module tb_clk_div_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_pass = 0;
  logic bdone = 1'b0;
  always #5 clk = ~clk;

  clk_div_multi_if #(.CH(4), .CNT_W(8)) ifa ();
  clk_div_multi_if #(.CH(3), .CNT_W(4)) ifb ();
  clk_div_multi #(.CH(4), .CNT_W(8), .DEFAULT_DIV(4))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
  clk_div_multi #(.CH(3), .CNT_W(4), .DEFAULT_DIV(15)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // model: per channel the number of running edges since the last restart; outputs follow from k/D
  int md [2][4];
  int mk [2][4];
  int mt [2][4];

  task automatic mstep(input int u, input logic [3:0] en, input logic sync, input logic we,
                       input int ch, input int dv);
    for (int i = 0; i < (u ? 3 : 4); i++) begin
      if (sync || (we && ch == i)) begin
        if (we && ch == i) md[u][i] = dv;
        mk[u][i] = 0;
        mt[u][i] = 0;
      end else if (md[u][i] == 0) begin
        mk[u][i] = 0;
        mt[u][i] = 0;
      end else if (!en[i]) begin
        mt[u][i] = 0;
      end else begin
        mk[u][i]++;
        mt[u][i] = (mk[u][i] % md[u][i] == 0) ? 1 : 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < 4; i++) begin
          md[u][i] = u ? 15 : 4;
          mk[u][i] = 0;
          mt[u][i] = 0;
        end
    end else begin
      mstep(0, ifa.en, ifa.sync, ifa.cfg_we, int'(ifa.cfg_ch), int'(ifa.cfg_div));
      mstep(1, {1'b0, ifb.en}, ifb.sync, ifb.cfg_we, int'(ifb.cfg_ch), int'(ifb.cfg_div));
    end

  function automatic int exp_clk(input int u);
    int v = 0;
    for (int i = 0; i < (u ? 3 : 4); i++)
      if (md[u][i] != 0 && (mk[u][i] / md[u][i]) % 2 == 1) v |= 1 << i;
    return v;
  endfunction

  function automatic int exp_tick(input int u);
    int v = 0;
    for (int i = 0; i < (u ? 3 : 4); i++) if (mt[u][i] != 0) v |= 1 << i;
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    chk("model_a_clk_out", int'(ifa.clk_out), exp_clk(0));
    chk("model_a_tick", int'(ifa.tick), exp_tick(0));
    chk("model_b_clk_out", int'(ifb.clk_out), exp_clk(1));
    chk("model_b_tick", int'(ifb.tick), exp_tick(1));
  end

  // build B: max divide 15 at CNT_W=4, plus an out-of-range channel write
  initial begin
    ifb.en = 3'b111; ifb.sync = 1'b0; ifb.cfg_we = 1'b0; ifb.cfg_ch = '0; ifb.cfg_div = '0;
    @(negedge rst);
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      chk("b_tick0_period30", int'(ifb.tick[0]), (e % 15 == 0) ? 1 : 0);
      chk("b_clk0_period30", int'(ifb.clk_out[0]), (e / 15) % 2);
      @(negedge clk);
      ifb.cfg_we = (e == 19); ifb.cfg_ch = 2'd3; ifb.cfg_div = 4'd2;
    end
    ifb.cfg_we = 1'b0;
    bdone = 1'b1;
  end

  initial begin
    int n;
    ifa.en = 4'hF; ifa.sync = 1'b0; ifa.cfg_we = 1'b0; ifa.cfg_ch = '0; ifa.cfg_div = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      chk("reset_tick0", int'(ifa.tick[0]), (e % 4 == 0) ? 1 : 0);
      if (e <= 8) chk("reset_clk0", int'(ifa.clk_out[0]), (e / 4) % 2);
    end
    @(negedge clk); ifa.cfg_we = 1'b1; ifa.cfg_ch = 2'd1; ifa.cfg_div = 8'd3;
    @(negedge clk); ifa.cfg_ch = 2'd2; ifa.cfg_div = 8'd1;
    @(negedge clk); ifa.cfg_we = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk("div1_tick2", int'(ifa.tick[2]), 1);
      chk("div1_clk2", int'(ifa.clk_out[2]), e % 2);
      chk("div3_tick1", int'(ifa.tick[1]), (e == 2) ? 1 : 0);
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ifa.tick[0] && n < 10);
    chk("wait_tick0", int'(ifa.tick[0]), 1);
    repeat (2) @(posedge clk);
    @(negedge clk); ifa.sync = 1'b1; ifa.cfg_we = 1'b1; ifa.cfg_ch = 2'd0; ifa.cfg_div = 8'd5;
    @(negedge clk); ifa.sync = 1'b0; ifa.cfg_we = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      chk("sync_wr_tick0", int'(ifa.tick[0]), (e == 5) ? 1 : 0);
      chk("sync_tick1", int'(ifa.tick[1]), (e % 3 == 0) ? 1 : 0);
      chk("sync_tick2", int'(ifa.tick[2]), 1);
    end
    @(negedge clk); ifa.cfg_we = 1'b1; ifa.cfg_ch = 2'd0; ifa.cfg_div = 8'd4;
    @(negedge clk); ifa.cfg_we = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      chk("pause_tick0", int'(ifa.tick[0]), (e == 7) ? 1 : 0);
      chk("pause_clk0", int'(ifa.clk_out[0]), (e >= 7) ? 1 : 0);
      @(negedge clk); ifa.en[0] = (e > 3);
    end
    ifa.cfg_we = 1'b1; ifa.cfg_ch = 2'd3; ifa.cfg_div = 8'd0;
    @(negedge clk); ifa.cfg_we = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      chk("park_tick3", int'(ifa.tick[3]), 0);
      chk("park_clk3", int'(ifa.clk_out[3]), 0);
    end
    wait (bdone);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ifa.clk_out[0] && n < 12);
    chk("wait_clk0_high", int'(ifa.clk_out[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a_clk", int'(ifa.clk_out), 0);
    chk("async_rst_a_tick", int'(ifa.tick), 0);
    chk("async_rst_b_clk", int'(ifb.clk_out), 0);
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      chk("post_rst_tick0", int'(ifa.tick[0]), (e % 4 == 0) ? 1 : 0);
      chk("post_rst_tick3", int'(ifa.tick[3]), (e % 4 == 0) ? 1 : 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
